// File: rtl/opcodes.sv
// Shared instruction/address types used across the fetch and decode stages.
package opcodes;

  typedef logic [31:0] instruction_t;
  typedef logic [31:0] address_t;

  localparam instruction_t NO_OP = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    address_t     pc;
    instruction_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instruction}; clear beats push, and a pop frees a slot
// for a same-cycle push even when full.
module fetch_queue
  import opcodes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   clear,
  output fetch_entry_t           pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             wr_s;
  logic             rd_s;

  assign full     = (count_r == FULL_CNT);
  assign empty    = (count_r == '0);
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Effective write/read strobes after full/empty qualification.
  always_comb begin
    wr_s = push && (!full || pop);
    rd_s = pop && !empty;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_checker.sv
// Protocol checks for the fetch stage: no queue overflow, no unsolicited response.
module instr_fetch_checker #(
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             q_push,
  input logic             q_full,
  input logic             q_pop,
  input logic             q_clear,
  input logic             imem_rvalid,
  input logic [CNT_W-1:0] outstanding
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full && !q_pop && !q_clear))
    else $fatal(1, "instr_fetch: prefetch queue overflow");

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (outstanding != '0))
    else $fatal(1, "instr_fetch: response with no outstanding request");

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: sequential PC issue with credit-limited prefetch, decoder hand-off
// with back-pressure, and redirect flush that drains stale in-flight responses.
module instr_fetch
  import opcodes::*;
#(
  parameter address_t RESET_PC    = 32'h0000_0000,
  parameter int       QUEUE_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output address_t     imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  address_t     redirect_pc,
  input  logic         dec_ready,
  output instruction_t instr,
  output address_t     instr_pc,
  output logic         enable
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  fetch_state_t     state_r;
  address_t         pc_r;
  address_t         rsp_pc_r;
  address_t         redir_pc_s;
  logic [CNT_W-1:0] outstanding_r;
  logic [CNT_W-1:0] outstanding_nxt_s;
  logic [CNT_W-1:0] q_count_s;
  logic             q_full_s;
  logic             q_empty_s;
  logic             q_push_s;
  logic             q_pop_s;
  logic             issue_s;
  fetch_entry_t     q_in_s;
  fetch_entry_t     q_head_s;
  instruction_t     instr_r;
  address_t         instr_pc_r;
  logic             enable_r;

  assign imem_addr = pc_r;
  assign instr     = instr_r;
  assign instr_pc  = instr_pc_r;
  assign enable    = enable_r;

  // Issue credit keeps queued + in-flight words within the queue, so every response has a slot.
  always_comb begin
    redir_pc_s = {redirect_pc[31:2], 2'b00};
    imem_req   = !rst && (state_r == RUN) && !redirect &&
                 (({1'b0, q_count_s} + {1'b0, outstanding_r}) < DEPTH_C);
    issue_s    = imem_req && imem_gnt;
    q_push_s   = (state_r == RUN) && imem_rvalid && !redirect;
    q_pop_s    = dec_ready && !q_empty_s && !redirect;
    q_in_s.pc    = rsp_pc_r;
    q_in_s.instr = imem_rdata;
    case ({issue_s, imem_rvalid})
      2'b10:   outstanding_nxt_s = outstanding_r + ONE_C;
      2'b01:   outstanding_nxt_s = outstanding_r - ONE_C;
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // PC, response tag, credit counter, RUN/FLUSH state and decoder-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= '0;
      state_r       <= RUN;
      instr_r       <= NO_OP;
      instr_pc_r    <= 32'h0000_0000;
      enable_r      <= 1'b0;
    end else begin
      outstanding_r <= outstanding_nxt_s;
      if (redirect) begin
        pc_r     <= redir_pc_s;
        rsp_pc_r <= redir_pc_s;
      end else begin
        if (issue_s)  pc_r     <= pc_r + 32'd4;
        if (q_push_s) rsp_pc_r <= rsp_pc_r + 32'd4;
      end
      case (state_r)
        RUN:     state_r <= (redirect && (outstanding_nxt_s != '0)) ? FLUSH : RUN;
        FLUSH:   state_r <= (!redirect && (outstanding_nxt_s == '0)) ? RUN : FLUSH;
        default: state_r <= RUN;
      endcase
      enable_r <= q_pop_s;
      if (q_pop_s) begin
        instr_r    <= q_head_s.instr;
        instr_pc_r <= q_head_s.pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push_s),
    .push_data(q_in_s),
    .pop      (q_pop_s),
    .clear    (redirect),
    .pop_data (q_head_s),
    .count    (q_count_s),
    .full     (q_full_s),
    .empty    (q_empty_s)
  );

  instr_fetch_checker #(
    .CNT_W(CNT_W)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .q_push     (q_push_s),
    .q_full     (q_full_s),
    .q_pop      (q_pop_s),
    .q_clear    (redirect),
    .imem_rvalid(imem_rvalid),
    .outstanding(outstanding_r)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench: in-order memory model with epochs marks stale responses;
// live responses feed an expected-instruction queue checked at every enable.
module tb_instr_fetch;
  import opcodes::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_req;
  address_t     imem_addr;
  logic         imem_gnt = 1'b0;
  logic         imem_rvalid = 1'b0;
  logic [31:0]  imem_rdata = 32'h0;
  logic         redirect = 1'b0;
  address_t     redirect_pc = 32'h0;
  logic         dec_ready = 1'b0;
  instruction_t instr;
  address_t     instr_pc;
  logic         enable;

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;

  mreq_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] en_log[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, lat = 1, epoch = 0, n_req = 0, n_en = 0, n_stale = 0;
  int first_gnt = -1, first_en = -1;
  bit rand_gnt = 1'b0, hold_req = 1'b0;
  logic [31:0] req_pc = RST_PC;
  logic [31:0] last_en_pc = 32'h0;

  instr_fetch #(.RESET_PC(RST_PC), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .instr(instr), .instr_pc(instr_pc), .enable(enable)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: memory drives response/grant, grants recorded, outputs scored at negedge.
  task automatic cycle();
    mreq_t r;
    exp_t  e;
    bit    deliver;
    int    stale_pend;
    deliver     = !rst && (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid = deliver;
    imem_rdata  = deliver ? mem_word(pend[0].addr) : 32'h0;
    imem_gnt    = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (redirect) check("req_redir", {31'b0, imem_req}, 32'd0);
    else if (hold_req && !rst) check("req_hold", {31'b0, imem_req}, 32'd1);
    if (imem_req) begin
      stale_pend = 0;
      foreach (pend[i]) if (pend[i].epoch != epoch) stale_pend++;
      check("req_flush", stale_pend, 32'd0);
      check("addr", imem_addr, req_pc);
      if (imem_gnt) begin
        pend.push_back('{addr: imem_addr, due: cyc + lat, epoch: epoch});
        req_pc = req_pc + 32'd4;
        n_req++;
        if (first_gnt < 0) first_gnt = cyc;
      end
    end
    hold_req = imem_req && !imem_gnt;
    if (deliver) begin
      r = pend.pop_front();
      if (redirect || r.epoch != epoch) n_stale++;
      else exp_q.push_back('{addr: r.addr, data: mem_word(r.addr)});
    end
    if (redirect) begin
      exp_q.delete();
      epoch++;
      req_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (enable) begin
      check("en_expected", {31'b0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e.addr);
        check("instr", instr, e.data);
      end
      n_en++;
      last_en_pc = instr_pc;
      en_log.push_back(instr_pc);
      if (first_en < 0) first_en = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_en(input int n, input int max);
    int target;
    int k;
    target = n_en + n;
    k = 0;
    while (n_en < target && k < max) begin
      cycle();
      k++;
    end
    check("wait_en", {31'b0, (n_en >= target)}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    pend.delete();
    exp_q.delete();
    epoch++;
    req_pc = RST_PC;
    hold_req = 1'b0;
    cycle();
    check("rst_en", {31'b0, enable}, 32'd0);
    check("rst_instr", instr, NO_OP);
    check("rst_ipc", instr_pc, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    cycle();
    rst = 1'b0;
    first_gnt = -1;
    first_en = -1;
  endtask

  initial begin
    int c0;
    int s0;
    // Streaming after reset with a 1-cycle memory: latency and throughput.
    lat = 1;
    do_reset();
    dec_ready = 1'b1;
    wait_en(1, 20);
    check("first_lat", first_en - first_gnt, 32'd3);
    c0 = n_en;
    run(12);
    check("thruput", n_en - c0, 32'd12);

    // Back-pressure: credit stops issue at 4, then burst drain and resume at 0x10.
    do_reset();
    dec_ready = 1'b0;
    c0 = n_req;
    run(20);
    check("req_cnt4", n_req - c0, 32'd4);
    check("req_idle", {31'b0, imem_req}, 32'd0);
    dec_ready = 1'b1;
    c0 = n_en;
    run(4);
    check("b2b4", n_en - c0, 32'd4);
    run(6);

    // 3-cycle memory, redirect with two in flight.
    lat = 3;
    do_reset();
    dec_ready = 1'b1;
    run(2);
    s0 = n_stale;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    wait_en(1, 30);
    check("stale2", n_stale - s0, 32'd2);
    check("flush_pc", last_en_pc, 32'h0000_0100);

    // Redirect colliding with a response and a pending request; low bits ignored.
    lat = 1;
    do_reset();
    dec_ready = 1'b1;
    run(6);
    s0 = n_stale;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    cycle();
    redirect = 1'b0;
    wait_en(1, 20);
    check("drop1", n_stale - s0, 32'd1);
    check("align_pc", last_en_pc, 32'h0000_0200);

    // Address wrap at the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    en_log.delete();
    wait_en(4, 30);
    if (en_log.size() >= 4) begin
      check("wrap0", en_log[0], 32'hFFFF_FFF8);
      check("wrap1", en_log[1], 32'hFFFF_FFFC);
      check("wrap2", en_log[2], 32'h0000_0000);
      check("wrap3", en_log[3], 32'h0000_0004);
    end else begin
      check("wrap_cnt", en_log.size(), 32'd4);
    end

    // Reset mid-stream with a full queue and the decoder just becoming ready.
    dec_ready = 1'b0;
    run(10);
    dec_ready = 1'b1;
    do_reset();
    wait_en(1, 20);
    check("rst_restart", last_en_pc, RST_PC);

    // Random back-pressure, grant stalls and redirects.
    lat = 2;
    rand_gnt = 1'b1;
    for (int i = 0; i < 300; i++) begin
      dec_ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    redirect = 1'b0;
    rand_gnt = 1'b0;
    dec_ready = 1'b1;
    wait_en(3, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
